// File: rtl/mc_controller.sv
// Multicycle control unit for the MIPS-subset datapath: Moore FSM with memory
// wait handshake, bne support, illegal-opcode trap and retired-instruction counter.
module mc_controller #(
    parameter int OPW         = 6,
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPW-1:0]   opcode,
    input  logic [5:0]       func,
    input  logic             mem_ready,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             Mem_or_I,
    output logic             wr31,
    output logic             wrdmux,
    output logic             mr,
    output logic             mw,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             ld_IR,
    output logic             Asel,
    output logic             br_inv,
    output logic [1:0]       pc_src,
    output logic [1:0]       Bsel,
    output logic [1:0]       alu_op,
    output logic             trap,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [4:0] {
        S_IF     = 5'd0,
        S_ID     = 5'd1,
        S_JC     = 5'd2,
        S_BC     = 5'd3,
        S_BNEC   = 5'd4,
        S_RTE    = 5'd5,
        S_RTC    = 5'd6,
        S_MAC    = 5'd7,
        S_SWC    = 5'd8,
        S_MA     = 5'd9,
        S_LWC    = 5'd10,
        S_ADDIEX = 5'd11,
        S_ADDIC  = 5'd12,
        S_SLTIEX = 5'd13,
        S_SLTIC  = 5'd14,
        S_JALC   = 5'd15,
        S_JRC    = 5'd16,
        S_TRAP   = 5'd17
    } state_e;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_JAL   = OPW'(6'b000011);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
    localparam logic [OPW-1:0] OP_JR    = OPW'(6'b000110);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001001);
    localparam logic [OPW-1:0] OP_SLTI  = OPW'(6'b001010);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              mem_ok;
    logic              retire;

    // func is decoded by the ALU controller in the datapath, not here.
    logic unused_func;
    assign unused_func = ^func;

    assign mem_ok = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:     if (mem_ok) state_d = S_ID;
            S_ID: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MAC;
                    OP_RTYPE:     state_d = S_RTE;
                    OP_BEQ:       state_d = S_BC;
                    OP_BNE:       state_d = S_BNEC;
                    OP_J:         state_d = S_JC;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_JAL:       state_d = S_JALC;
                    OP_JR:        state_d = S_JRC;
                    OP_SLTI:      state_d = S_SLTIEX;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MAC:    state_d = (opcode == OP_SW) ? S_SWC : S_MA;
            S_SWC:    if (mem_ok) state_d = S_IF;
            S_MA:     if (mem_ok) state_d = S_LWC;
            S_RTE:    state_d = S_RTC;
            S_ADDIEX: state_d = S_ADDIC;
            S_SLTIEX: state_d = S_SLTIC;
            S_JC, S_JRC, S_JALC, S_BC, S_BNEC,
            S_RTC, S_ADDIC, S_SLTIC, S_LWC:
                      state_d = S_IF;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IF;
        endcase
    end

    always_comb begin
        case (state_q)
            S_JC, S_JRC, S_JALC, S_BC, S_BNEC,
            S_RTC, S_ADDIC, S_SLTIC, S_LWC, S_SWC: retire = (state_d == S_IF);
            default:                              retire = 1'b0;
        endcase
        count_d = retire ? count_q + CNT_W'(1) : count_q;
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IF;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign instr_count = count_q;

    always_comb begin
        // NOTE: every output gets a default before the case, otherwise latches are inferred.
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        Mem_or_I    = 1'b0;
        wr31        = 1'b0;
        wrdmux      = 1'b0;
        mr          = 1'b0;
        mw          = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        ld_IR       = 1'b0;
        Asel        = 1'b0;
        br_inv      = 1'b0;
        pc_src      = 2'b00;
        Bsel        = 2'b00;
        alu_op      = 2'b00;
        trap        = 1'b0;
        case (state_q)
            S_IF: begin
                mr      = 1'b1;
                Bsel    = 2'b01;
                ld_IR   = mem_ok;
                PCWrite = mem_ok;
            end
            S_ID:     Bsel = 2'b11;
            S_BC, S_BNEC: begin
                Asel        = 1'b1;
                alu_op      = 2'b01;
                PCWriteCond = 1'b1;
                pc_src      = 2'b10;
                br_inv      = (state_q == S_BNEC);
            end
            S_JC: begin
                pc_src  = 2'b01;
                PCWrite = 1'b1;
            end
            S_JRC: begin
                pc_src  = 2'b11;
                PCWrite = 1'b1;
            end
            S_JALC: begin
                wrdmux    = 1'b1;
                wr31      = 1'b1;
                reg_write = 1'b1;
                pc_src    = 2'b01;
                PCWrite   = 1'b1;
            end
            S_RTE: begin
                Asel   = 1'b1;
                alu_op = 2'b10;
            end
            S_RTC: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_ADDIEX, S_MAC: begin
                Asel = 1'b1;
                Bsel = 2'b10;
            end
            S_SLTIEX: begin
                Asel   = 1'b1;
                Bsel   = 2'b10;
                alu_op = 2'b11;
            end
            S_ADDIC, S_SLTIC: reg_write = 1'b1;
            S_SWC: begin
                mw       = 1'b1;
                Mem_or_I = 1'b1;
            end
            S_MA: begin
                mr       = 1'b1;
                Mem_or_I = 1'b1;
            end
            S_LWC: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_TRAP:   trap = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus pushes per-cycle expected controls,
// a negedge monitor pops and compares against two DUT configurations.
module tb_mc_controller;

    typedef struct packed {
        logic       reg_dst, mem_to_reg, reg_write, mem_or_i, wr31, wrdmux, mr, mw;
        logic       pcwrite, pcwritecond, ld_ir, asel, br_inv;
        logic [1:0] pc_src, bsel, alu_op;
        logic       trap;
    } ctrl_t;

    typedef struct {
        bit          which;
        string       name;
        ctrl_t       ctrl;
        logic [15:0] cnt;
    } exp_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_JR = 6'b000110,
                           OP_ADDI = 6'b001001, OP_SLTI = 6'b001010, OP_LW = 6'b100011,
                           OP_SW = 6'b101011, OP_BAD = 6'b111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, mr1, rst2, mr2;
    logic [5:0]  op1, op2;
    logic [5:0]  func = 6'b100000;
    ctrl_t       act1, act2;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    mc_controller dut1 (
        .clk(clk), .rst(rst1), .opcode(op1), .func(func), .mem_ready(mr1),
        .reg_dst(act1.reg_dst), .mem_to_reg(act1.mem_to_reg), .reg_write(act1.reg_write),
        .Mem_or_I(act1.mem_or_i), .wr31(act1.wr31), .wrdmux(act1.wrdmux), .mr(act1.mr),
        .mw(act1.mw), .PCWrite(act1.pcwrite), .PCWriteCond(act1.pcwritecond),
        .ld_IR(act1.ld_ir), .Asel(act1.asel), .br_inv(act1.br_inv), .pc_src(act1.pc_src),
        .Bsel(act1.bsel), .alu_op(act1.alu_op), .trap(act1.trap), .instr_count(cnt1)
    );

    mc_controller #(.OPW(6), .MEM_WAIT_EN(1'b0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .opcode(op2), .func(func), .mem_ready(mr2),
        .reg_dst(act2.reg_dst), .mem_to_reg(act2.mem_to_reg), .reg_write(act2.reg_write),
        .Mem_or_I(act2.mem_or_i), .wr31(act2.wr31), .wrdmux(act2.wrdmux), .mr(act2.mr),
        .mw(act2.mw), .PCWrite(act2.pcwrite), .PCWriteCond(act2.pcwritecond),
        .ld_IR(act2.ld_ir), .Asel(act2.asel), .br_inv(act2.br_inv), .pc_src(act2.pc_src),
        .Bsel(act2.bsel), .alu_op(act2.alu_op), .trap(act2.trap), .instr_count(cnt2)
    );

    // Hand-written control table; rdy is the effective memory-ready seen in IF.
    function automatic ctrl_t model(input string st, input logic rdy);
        ctrl_t c = '0;
        case (st)
            "IF":     begin c.mr = 1; c.bsel = 2'b01; c.ld_ir = rdy; c.pcwrite = rdy; end
            "ID":     c.bsel = 2'b11;
            "BC":     begin c.asel = 1; c.alu_op = 2'b01; c.pcwritecond = 1; c.pc_src = 2'b10; end
            "BNEC":   begin c.asel = 1; c.alu_op = 2'b01; c.pcwritecond = 1; c.pc_src = 2'b10;
                            c.br_inv = 1; end
            "JC":     begin c.pc_src = 2'b01; c.pcwrite = 1; end
            "JRC":    begin c.pc_src = 2'b11; c.pcwrite = 1; end
            "JALC":   begin c.wrdmux = 1; c.wr31 = 1; c.reg_write = 1; c.pc_src = 2'b01;
                            c.pcwrite = 1; end
            "RTE":    begin c.asel = 1; c.alu_op = 2'b10; end
            "RTC":    begin c.reg_dst = 1; c.reg_write = 1; end
            "ADDIEX", "MAC": begin c.asel = 1; c.bsel = 2'b10; end
            "SLTIEX": begin c.asel = 1; c.bsel = 2'b10; c.alu_op = 2'b11; end
            "ADDIC", "SLTIC": c.reg_write = 1;
            "SWC":    begin c.mw = 1; c.mem_or_i = 1; end
            "MA":     begin c.mr = 1; c.mem_or_i = 1; end
            "LWC":    begin c.reg_write = 1; c.mem_to_reg = 1; end
            "TRAP":   c.trap = 1;
            default:  c = 'x;
        endcase
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: apply inputs, queue the expected outputs for this cycle.
    task automatic cyc(input bit which, input string st, input logic rdy, input logic [5:0] op,
                       input logic rst_in, input int cnt);
        exp_t e;
        if (!which) begin mr1 = rdy; op1 = op; rst1 = rst_in; end
        else        begin mr2 = rdy; op2 = op; rst2 = rst_in; end
        e.which = which;
        e.name  = st;
        e.ctrl  = model(st, which ? 1'b1 : rdy);
        e.cnt   = 16'(cnt);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic c1(input string st, input logic rdy, input logic [5:0] op,
                      input logic rst_in, input int cnt);
        cyc(1'b0, st, rdy, op, rst_in, cnt);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (!e.which) begin
                check($sformatf("dut1 %s ctrl", e.name), 32'(act1), 32'(e.ctrl));
                check($sformatf("dut1 %s count", e.name), 32'(cnt1), 32'(e.cnt));
            end else begin
                check($sformatf("dut2 %s ctrl", e.name), 32'(act2), 32'(e.ctrl));
                check($sformatf("dut2 %s count", e.name), 32'(cnt2), 32'(e.cnt));
            end
        end
    end

    initial begin
        rst1 = 1'b0; mr1 = 1'b1; op1 = OP_R;
        rst2 = 1'b0; mr2 = 1'b0; op2 = OP_J;
        @(posedge clk);
        #1;

        // R-type: 4 cycles, count 0 -> 1
        c1("IF", 1, OP_R, 1, 0); c1("ID", 1, OP_R, 1, 0);
        c1("RTE", 1, OP_R, 1, 0); c1("RTC", 1, OP_R, 1, 0);
        // lw with a fetch wait and two MA wait cycles
        c1("IF", 0, OP_LW, 1, 1); c1("IF", 1, OP_LW, 1, 1); c1("ID", 1, OP_LW, 1, 1);
        c1("MAC", 1, OP_LW, 1, 1); c1("MA", 0, OP_LW, 1, 1); c1("MA", 0, OP_LW, 1, 1);
        c1("MA", 1, OP_LW, 1, 1); c1("LWC", 1, OP_LW, 1, 1);
        // branches and jumps
        c1("IF", 1, OP_BNE, 1, 2); c1("ID", 1, OP_BNE, 1, 2); c1("BNEC", 1, OP_BNE, 1, 2);
        c1("IF", 1, OP_BEQ, 1, 3); c1("ID", 1, OP_BEQ, 1, 3); c1("BC", 1, OP_BEQ, 1, 3);
        c1("IF", 1, OP_J, 1, 4);   c1("ID", 1, OP_J, 1, 4);   c1("JC", 1, OP_J, 1, 4);
        c1("IF", 1, OP_JR, 1, 5);  c1("ID", 1, OP_JR, 1, 5);  c1("JRC", 1, OP_JR, 1, 5);
        c1("IF", 1, OP_JAL, 1, 6); c1("ID", 1, OP_JAL, 1, 6); c1("JALC", 1, OP_JAL, 1, 6);
        // immediates
        c1("IF", 1, OP_ADDI, 1, 7); c1("ID", 1, OP_ADDI, 1, 7);
        c1("ADDIEX", 1, OP_ADDI, 1, 7); c1("ADDIC", 1, OP_ADDI, 1, 7);
        c1("IF", 1, OP_SLTI, 1, 8); c1("ID", 1, OP_SLTI, 1, 8);
        c1("SLTIEX", 1, OP_SLTI, 1, 8); c1("SLTIC", 1, OP_SLTI, 1, 8);
        // sw with two wait cycles
        c1("IF", 1, OP_SW, 1, 9); c1("ID", 1, OP_SW, 1, 9); c1("MAC", 1, OP_SW, 1, 9);
        c1("SWC", 0, OP_SW, 1, 9); c1("SWC", 0, OP_SW, 1, 9); c1("SWC", 1, OP_SW, 1, 9);
        // illegal opcode: trap holds for 10 cycles, then reset
        c1("IF", 1, OP_BAD, 1, 10); c1("ID", 1, OP_BAD, 1, 10);
        for (int i = 0; i < 10; i++) c1("TRAP", i[0], OP_R, 1, 10);
        c1("TRAP", 1, OP_R, 0, 10);
        // reset while waiting in SWC
        c1("IF", 1, OP_J, 1, 0); c1("ID", 1, OP_J, 1, 0); c1("JC", 1, OP_J, 1, 0);
        c1("IF", 1, OP_SW, 1, 1); c1("ID", 1, OP_SW, 1, 1); c1("MAC", 1, OP_SW, 1, 1);
        c1("SWC", 0, OP_SW, 1, 1); c1("SWC", 0, OP_SW, 0, 1);
        c1("IF", 0, OP_SW, 1, 0);

        // CNT_W=2, no memory wait: five jumps wrap the counter, then a 5-cycle lw
        rst1 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, "IF", 0, OP_J, 1, k % 4);
            cyc(1'b1, "ID", 0, OP_J, 1, k % 4);
            cyc(1'b1, "JC", 0, OP_J, 1, k % 4);
        end
        cyc(1'b1, "IF", 0, OP_LW, 1, 1); cyc(1'b1, "ID", 0, OP_LW, 1, 1);
        cyc(1'b1, "MAC", 0, OP_LW, 1, 1); cyc(1'b1, "MA", 0, OP_LW, 1, 1);
        cyc(1'b1, "LWC", 0, OP_LW, 1, 1); cyc(1'b1, "IF", 0, OP_LW, 1, 2);

        repeat (3) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Parametrised multicycle control unit for the MIPS-subset datapath. It replaces the fixed-latency controller. It extends that controller with a memory wait handshake, a `bne` path, an illegal-opcode trap state and a retired-instruction counter. It sits beside the multicycle datapath and drives its mux selects, register-file and memory strobes, PC write enables and ALU operation class. The existing ALU controller in the datapath decodes `alu_op`/`func` into the ALU operation.

## Interface
- `OPW`, 6: opcode width.
- `MEM_WAIT_EN`, 1: 1 = memory states wait for `mem_ready`; 0 = `mem_ready` ignored and treated as 1.
- `CNT_W`, 16: width of `instr_count`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `opcode`  in  OPW  instruction opcode from IR.
- `func`  in  6  R-type function field; passed through to the ALU controller, not decoded here.
- `mem_ready`  in  1  memory completes current access this cycle.
- `reg_dst`, `mem_to_reg`, `reg_write`, `Mem_or_I`, `wr31`, `wrdmux`, `mr`, `mw`  out  1 each  datapath controls; same meaning as the current controller.
- `PCWrite`, `PCWriteCond`, `ld_IR`, `Asel`  out  1 each  PC and IR load enables, ALU A select.
- `br_inv`  out  1  branch sense; datapath PC enable = `PCWrite | (PCWriteCond & (zero ^ br_inv))`.
- `pc_src`, `Bsel`, `alu_op`  out  2 each  PC source, ALU B select, ALU op class (00 add, 01 sub, 10 R-type, 11 slt).
- `trap`  out  1  illegal opcode seen; sticky until reset.
- `instr_count`  out  CNT_W  instructions retired since reset; wraps modulo 2^CNT_W.

## Operation
- Moore FSM, 18 states, 5-bit encoding: IF, ID, JC, BC, BNEC, RTE, RTC, MAC, SWC, MA, LWC, ADDIEX, ADDIC, SLTIEX, SLTIC, JALC, JRC, TRAP.
- All outputs default to 0 in every state. Only the listed signals are set.
- IF: `mr`=1, `Bsel`=01, `pc_src`=00. `ld_IR`=`PCWrite`=`mem_ready`. Exit to ID when `mem_ready`, otherwise hold.
- ID: `Bsel`=11. Next state is chosen by opcode:
  - 100011/101011 → MAC
  - 000000 → RTE
  - 000100 → BC
  - 000101 → BNEC
  - 000010 → JC
  - 001001 → ADDIEX
  - 000011 → JALC
  - 000110 → JRC
  - 001010 → SLTIEX
  - any other opcode → TRAP
- BC: `Asel`=1, `Bsel`=00, `alu_op`=01, `PCWriteCond`=1, `pc_src`=10. Next state IF.
- BNEC: same outputs as BC plus `br_inv`=1. Next state IF.
- JC: `pc_src`=01, `PCWrite`=1. Next state IF.
- JRC: `pc_src`=11, `PCWrite`=1. Next state IF.
- JALC: `wrdmux`=`wr31`=`reg_write`=1, `pc_src`=01, `PCWrite`=1. Next state IF.
- RTE: `Asel`=1, `Bsel`=00, `alu_op`=10. Next state RTC.
- RTC: `reg_dst`=`reg_write`=1. Next state IF.
- ADDIEX: `Asel`=1, `Bsel`=10, `alu_op`=00. Next state ADDIC.
- SLTIEX: `Asel`=1, `Bsel`=10, `alu_op`=11. Next state SLTIC.
- ADDIC and SLTIC: `reg_write`=1. Next state IF.
- MAC: `Asel`=1, `Bsel`=10, `alu_op`=00. Next state SWC for sw, MA for lw.
- SWC: `mw`=`Mem_or_I`=1. Hold until `mem_ready`, then IF.
- MA: `mr`=`Mem_or_I`=1. Hold until `mem_ready`, then LWC.
- LWC: `reg_write`=`mem_to_reg`=1. Next state IF.
- TRAP: all controls 0, `trap`=1. Stays in TRAP until reset.
- Retire: `instr_count` increments by 1 on each edge where the state moves from a completion state to IF. The completion states are JC, JRC, JALC, BC, BNEC, RTC, ADDIC, SLTIC, LWC and SWC.
- While waiting (`mem_ready`=0), outputs stay constant and no counter update happens.
- With `MEM_WAIT_EN`=0, every memory state lasts exactly 1 cycle.

## Timing
- Reset: while `rst`=0 at a rising edge, the next state is IF, `instr_count`=0 and `trap`=0. This applies in any state, including mid-wait and TRAP.
- Outputs after reset are the IF values: `mr`=1, `Bsel`=01, and all others 0 except `ld_IR`/`PCWrite`, which follow `mem_ready`.
- Outputs are combinational from state (plus `mem_ready` in IF only). There are no glitches from `opcode`, because `opcode` is only sampled in ID and MAC.
- Zero-wait latency in cycles, IF to IF:
  - j, jr, jal, beq, bne: 3
  - R-type, addi, slti, sw: 4
  - lw: 5
- Each wait cycle in IF, MA or SWC adds 1 cycle.
- `instr_count` is visible on the cycle the FSM re-enters IF.
- At wrap, 2^CNT_W−1 goes to 0 with no flag.

## Test plan
- R-type add, `mem_ready`=1 constant → states IF, ID, RTE, RTC, IF in 4 cycles. RTC has `reg_dst`=`reg_write`=1. `instr_count` goes 0→1.
- lw with `mem_ready` low for 2 cycles in MA → MA lasts 3 cycles with `mr`=`Mem_or_I`=1 stable. LWC follows and the total is 7 cycles.
- bne (opcode 000101) → BNEC asserts `PCWriteCond`=1, `br_inv`=1, `pc_src`=10, `alu_op`=01.
- Opcode 111111 → TRAP after ID with `trap`=1 and all strobes 0. The FSM stays in TRAP for 10 cycles. Then `rst`=0 for one edge → IF, `trap`=0.
- Reset asserted in SWC while `mw`=1 and waiting → next edge IF with `mw`=0 and `instr_count`=0.
- CNT_W=2: retire 5 jumps → `instr_count` sequence 1,2,3,0,1.
